diff_unit_pipe: RTL

DIFF_UNIT_PIPE -- requirements
Module: diff_unit_pipe

---
 rtl/diff_unit_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/diff_unit_pipe.sv
// Two-stage differing-bit analyser: stage 1 captures A^B and mode, stage 2 captures
// the lowest/highest differing bit index or the Hamming distance.

module diff_unit_enc #(
    parameter int WIDTH = 32,
    parameter int RW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       mode,
    output logic [RW-1:0]    result,
    output logic             none
);
    logic [WIDTH-1:0] iso;
    logic [RW-1:0]    lo_idx;
    logic [RW-1:0]    hi_idx;
    logic [RW-1:0]    cnt;

    // iso is one-hot on the lowest set bit, so OR-ing indices encodes it.
    always_comb begin
        iso    = x & ~(x - WIDTH'(1));
        lo_idx = '0;
        hi_idx = '0;
        cnt    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (iso[i]) lo_idx = lo_idx | RW'(i);
            if (x[i])   hi_idx = RW'(i);
            cnt = cnt + RW'(x[i]);
        end
    end

    // All three candidates are zero when x is zero, so none needs no extra muxing.
    always_comb begin
        none = (x == '0);
        case (mode)
            2'b01:   result = hi_idx;
            2'b10:   result = cnt;
            default: result = lo_idx;
        endcase
    end
endmodule

module diff_unit_pipe #(
    parameter  int WIDTH = 32,
    localparam int RW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    result,
    output logic             none
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [1:0]       s1_mode;
    logic             s2_free;
    logic             accept;
    logic [RW-1:0]    enc_result;
    logic             enc_none;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    // Stage 1 empties whenever stage 2 can take it, and refills on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_mode  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_x     <= A ^ B;
            s1_mode  <= mode;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    diff_unit_enc #(.WIDTH(WIDTH), .RW(RW)) u_enc (
        .x      (s1_x),
        .mode   (s1_mode),
        .result (enc_result),
        .none   (enc_none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            none      <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= enc_result;
                none   <= enc_none;
            end
        end
    end
endmodule
